// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
// Change dispenser: pays out a refund as 2- and 1-rupee coins from two hoppers.
// It reports the coins paid and any amount left unpaid, and raises a sticky fault if a hopper jams.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refund_valid,
    input  logic [3:0] refund_amount,
    output logic       refund_ready,
    input  logic       empty_2,
    input  logic       empty_1,
    output logic       coin_out_2,
    output logic       coin_out_1,
    input  logic       hopper_ack,
    output logic       done,
    output logic [3:0] shortfall,
    output logic [3:0] coins_paid,
    output logic       fault
);

    // state  | meaning
    // IDLE   | ready for a refund
    // SELECT | pick next coin from remaining amount and hopper stock
    // REQ2   | 2-rupee eject requested, waiting for ack
    // REQ1   | 1-rupee eject requested, waiting for ack
    // GAP    | one quiet cycle between coins
    // DONE   | done pulse, results held
    // FAULT  | hopper jam, parked until reset
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        REQ2   = 3'd2,
        REQ1   = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    state_t            state;
    logic [3:0]        remaining;
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            remaining    <= 4'd0;
            coins_paid   <= 4'd0;
            shortfall    <= 4'd0;
            wait_cnt     <= '0;
            coin_out_2   <= 1'b0;
            coin_out_1   <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            refund_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (refund_valid) begin
                        remaining    <= refund_amount;
                        coins_paid   <= 4'd0;
                        shortfall    <= 4'd0;
                        refund_ready <= 1'b0;
                        state        <= SELECT;
                    end
                end

                SELECT: begin
                    wait_cnt <= '0;
                    if (remaining >= 4'd2 && !empty_2) begin
                        coin_out_2 <= 1'b1;
                        state      <= REQ2;
                    end else if (remaining != 4'd0 && !empty_1) begin
                        coin_out_1 <= 1'b1;
                        state      <= REQ1;
                    end else begin
                        shortfall <= remaining;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                // An ack on the last allowed cycle still wins over the timeout.
                REQ2, REQ1: begin
                    if (hopper_ack) begin
                        remaining  <= remaining - ((state == REQ2) ? 4'd2 : 4'd1);
                        coins_paid <= coins_paid + 4'd1;
                        coin_out_2 <= 1'b0;
                        coin_out_1 <= 1'b0;
                        state      <= GAP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        coin_out_2 <= 1'b0;
                        coin_out_1 <= 1'b0;
                        fault      <= 1'b1;
                        state      <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                GAP: begin
                    state <= SELECT;
                end

                DONE: begin
                    refund_ready <= 1'b1;
                    state        <= IDLE;
                end

                FAULT: begin
                    fault <= 1'b1;
                    state <= FAULT;
                end

                default: begin
                    coin_out_2   <= 1'b0;
                    coin_out_1   <= 1'b0;
                    refund_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
